// File: rtl/morse_pkg.sv
// Shared types and timing thresholds for the Morse pulse decoder.
// Thresholds are in Morse units; the instantiating block scales them by its unit length.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   typedef enum logic {
      DOT  = 1'b0,
      DASH = 1'b1
   } elem_t;

   localparam int DASH_UNITS       = 2;
   localparam int LETTER_GAP_UNITS = 2;
   localparam int WORD_GAP_UNITS   = 5;
   localparam int SAT_UNITS        = 7;

   function automatic int dur_width(input int unit_cycles);
      return $clog2(SAT_UNITS * unit_cycles + 1);
   endfunction

endpackage

// File: rtl/morse_input_filter.sv
// Synchronises the raw on/off input and rejects pulses shorter than GLITCH_CYCLES.
// Produces the accepted level plus one-cycle strobes in the first cycle of each new level.
module morse_input_filter #(
   parameter int GLITCH_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(GLITCH_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          rise_r;
   logic          fall_r;
   logic [CW-1:0] cnt_r;

   // Two-flop synchroniser for the asynchronous input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= sig;
         sync2_r <= sync1_r;
      end
   end

   // Level flips once the synchronised input has disagreed for GLITCH_CYCLES cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               rise_r  <= sync2_r;
               fall_r  <= ~sync2_r;
               cnt_r   <= {CW{1'b0}};
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end else begin
            cnt_r <= {CW{1'b0}};
         end
      end
   end

   assign level = level_r;
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/morse_pulse_decoder.sv
// Decodes filtered on/off keying into Morse letters: times marks and spaces,
// accumulates dot/dash elements and reports one letter per letter gap plus word ends.
module morse_pulse_decoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES   = 2097152,
   parameter int GLITCH_CYCLES = 1024,
   parameter int MAX_ELEMS     = 6
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 SIG,
   output logic                 SYM_VALID,
   output logic [MAX_ELEMS-1:0] SYM_CODE,
   output logic [2:0]           SYM_LEN,
   output logic                 SYM_ERR,
   output logic                 WORD_END,
   output logic                 LED
);

   localparam int DW = dur_width(UNIT_CYCLES);
   localparam logic [DW-1:0] DUR_ONE    = DW'(1);
   localparam logic [DW-1:0] DUR_DASH   = DW'(DASH_UNITS * UNIT_CYCLES);
   localparam logic [DW-1:0] DUR_LETTER = DW'(LETTER_GAP_UNITS * UNIT_CYCLES);
   localparam logic [DW-1:0] DUR_WORD   = DW'(WORD_GAP_UNITS * UNIT_CYCLES);
   localparam logic [DW-1:0] DUR_SAT    = DW'(SAT_UNITS * UNIT_CYCLES);
   localparam logic [2:0]    LEN_MAX    = 3'(MAX_ELEMS);

   logic                 level_s;
   logic                 rise_s;
   logic                 fall_s;
   logic [DW-1:0]        dur_r;
   state_t               state_r,     state_s;
   logic [MAX_ELEMS-1:0] code_r,      code_s;
   logic [2:0]           len_r,       len_s;
   logic                 err_r,       err_s;
   logic                 sym_valid_r, sym_valid_s;
   logic                 word_end_r,  word_end_s;
   logic [MAX_ELEMS-1:0] sym_code_r,  sym_code_s;
   logic [2:0]           sym_len_r,   sym_len_s;
   logic                 sym_err_r,   sym_err_s;
   elem_t                elem_s;
   logic [MAX_ELEMS-1:0] elem_vec_s;

   morse_input_filter #(
      .GLITCH_CYCLES(GLITCH_CYCLES)
   ) u_filter (
      .clk  (CLK),
      .rst_n(RESETN),
      .sig  (SIG),
      .level(level_s),
      .rise (rise_s),
      .fall (fall_s)
   );

   // Cycles since the last filtered edge, saturating
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         dur_r <= {DW{1'b0}};
      end else if (rise_s || fall_s) begin
         dur_r <= DUR_ONE;
      end else if (dur_r != DUR_SAT) begin
         dur_r <= dur_r + DW'(1);
      end else begin
         dur_r <= dur_r;
      end
   end

   // Next-state, accumulator and output decisions; an edge always pre-empts a gap threshold
   always_comb begin
      state_s     = state_r;
      code_s      = code_r;
      len_s       = len_r;
      err_s       = err_r;
      sym_valid_s = 1'b0;
      word_end_s  = 1'b0;
      sym_code_s  = sym_code_r;
      sym_len_s   = sym_len_r;
      sym_err_s   = sym_err_r;
      elem_s      = (dur_r >= DUR_DASH) ? DASH : DOT;
      elem_vec_s  = {{(MAX_ELEMS-1){1'b0}}, elem_s};
      case (state_r)
         IDLE: begin
            if (rise_s) begin
               state_s = MARK;
            end else begin
               state_s = IDLE;
            end
         end
         MARK: begin
            if (fall_s) begin
               if (len_r < LEN_MAX) begin
                  code_s = code_r | (elem_vec_s << len_r);
                  len_s  = len_r + 3'd1;
               end else begin
                  err_s = 1'b1;
               end
               state_s = SPACE;
            end else begin
               state_s = MARK;
            end
         end
         SPACE: begin
            if (rise_s) begin
               state_s = MARK;
            end else if (dur_r == DUR_LETTER) begin
               sym_valid_s = 1'b1;
               sym_code_s  = code_r;
               sym_len_s   = len_r;
               sym_err_s   = err_r;
               code_s      = {MAX_ELEMS{1'b0}};
               len_s       = 3'd0;
               err_s       = 1'b0;
            end else if (dur_r == DUR_WORD) begin
               word_end_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s = SPACE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, letter accumulator and registered outputs
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r     <= IDLE;
         code_r      <= {MAX_ELEMS{1'b0}};
         len_r       <= 3'd0;
         err_r       <= 1'b0;
         sym_valid_r <= 1'b0;
         word_end_r  <= 1'b0;
         sym_code_r  <= {MAX_ELEMS{1'b0}};
         sym_len_r   <= 3'd0;
         sym_err_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         code_r      <= code_s;
         len_r       <= len_s;
         err_r       <= err_s;
         sym_valid_r <= sym_valid_s;
         word_end_r  <= word_end_s;
         sym_code_r  <= sym_code_s;
         sym_len_r   <= sym_len_s;
         sym_err_r   <= sym_err_s;
      end
   end

   assign SYM_VALID = sym_valid_r;
   assign SYM_CODE  = sym_code_r;
   assign SYM_LEN   = sym_len_r;
   assign SYM_ERR   = sym_err_r;
   assign WORD_END  = word_end_r;
   assign LED       = level_s;

endmodule

// File: tb/tb_morse_pulse_decoder.sv
// Bench for morse_pulse_decoder: directed Morse patterns plus random keying, checked every
// cycle against a run-length model of the filtered level and the letter/word rules.
module tb_morse_pulse_decoder;

   localparam int U = 16;
   localparam int G = 2;
   localparam int M = 6;

   logic         CLK = 1'b0;
   logic         RESETN = 1'b0;
   logic         SIG = 1'b0;
   logic         SYM_VALID;
   logic [M-1:0] SYM_CODE;
   logic [2:0]   SYM_LEN;
   logic         SYM_ERR;
   logic         WORD_END;
   logic         LED;

   always #5 CLK = ~CLK;

   morse_pulse_decoder #(
      .UNIT_CYCLES  (U),
      .GLITCH_CYCLES(G),
      .MAX_ELEMS    (M)
   ) dut (
      .CLK      (CLK),
      .RESETN   (RESETN),
      .SIG      (SIG),
      .SYM_VALID(SYM_VALID),
      .SYM_CODE (SYM_CODE),
      .SYM_LEN  (SYM_LEN),
      .SYM_ERR  (SYM_ERR),
      .WORD_END (WORD_END),
      .LED      (LED)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // model: raw sample history, filtered level, run length, letter in progress
   logic         hist [0:G+1];
   logic         m_led;
   int           run;
   int           mode;      // 0 idle, 1 mark, 2 space
   logic [M-1:0] acc_code;
   int           acc_len;
   logic         acc_err;
   logic         p_sv, p_we, p_err;
   logic [M-1:0] p_code;
   int           p_len;
   logic         e_sv, e_we, e_err;
   logic [M-1:0] e_code;
   logic [2:0]   e_len;

   // observed DUT events
   int           sv_cyc[$];
   int           sv_code[$];
   int           sv_len[$];
   int           sv_err[$];
   int           we_cyc[$];
   int           led_hi = 0;

   task automatic model_reset();
      for (int k = 0; k <= G + 1; k++) hist[k] = 1'b0;
      m_led = 1'b0; run = 0; mode = 0;
      acc_code = '0; acc_len = 0; acc_err = 1'b0;
      p_sv = 1'b0; p_we = 1'b0; p_err = 1'b0; p_code = '0; p_len = 0;
      e_sv = 1'b0; e_we = 1'b0; e_err = 1'b0; e_code = '0; e_len = 3'd0;
   endtask

   task automatic model_step();
      logic all_diff;
      logic new_led;
      if (!RESETN) begin
         model_reset();
      end else begin
         e_sv = p_sv;
         e_we = p_we;
         if (p_sv) begin
            e_code = p_code; e_len = 3'(p_len); e_err = p_err;
         end
         p_sv = 1'b0;
         p_we = 1'b0;
         for (int k = G + 1; k >= 1; k--) hist[k] = hist[k-1];
         hist[0] = SIG;
         all_diff = 1'b1;
         for (int k = 2; k <= G + 1; k++) if (hist[k] == m_led) all_diff = 1'b0;
         new_led = all_diff ? ~m_led : m_led;
         if (new_led != m_led) begin
            if (new_led) begin
               mode = 1;
            end else if (mode == 1) begin
               if (acc_len < M) begin
                  acc_code[acc_len] = (run >= 2 * U);
                  acc_len++;
               end else begin
                  acc_err = 1'b1;
               end
               mode = 2;
            end
            run = 1;
            m_led = new_led;
         end else begin
            if (run < 100000) run++;
            if (mode == 2 && run == 2 * U + 1) begin
               p_sv = 1'b1; p_code = acc_code; p_len = acc_len; p_err = acc_err;
               acc_code = '0; acc_len = 0; acc_err = 1'b0;
            end
            if (mode == 2 && run == 5 * U + 1) begin
               p_we = 1'b1;
               mode = 0;
            end
         end
      end
   endtask

   task automatic cycle_check();
      logic [12:0] act;
      logic [12:0] exp;
      act = {SYM_VALID, SYM_CODE, SYM_LEN, SYM_ERR, WORD_END, LED};
      exp = {e_sv, e_code, e_len, e_err, e_we, m_led};
      cyc++;
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cycle_cmp @%0d: dut=%b model=%b (valid,code,len,err,word,led)", cyc, act, exp);
      end
      if (SYM_VALID === 1'b1) begin
         sv_cyc.push_back(cyc);
         sv_code.push_back(int'(SYM_CODE));
         sv_len.push_back(int'(SYM_LEN));
         sv_err.push_back(int'(SYM_ERR));
      end
      if (WORD_END === 1'b1) we_cyc.push_back(cyc);
      if (LED === 1'b1) led_hi++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input int n);
      SIG = v;
      repeat (n) begin
         @(posedge CLK);
         model_step();
         @(negedge CLK);
         cycle_check();
      end
      #1;
   endtask

   task automatic send(input string pat, input int gap_units);
      for (int i = 0; i < pat.len(); i++) begin
         drive(1'b1, (pat[i] == "-") ? 3 * U : U);
         drive(1'b0, (i == pat.len() - 1) ? gap_units * U : U);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic int rnd_mark();
      case ($urandom_range(0, 5))
         0: return 1;
         1: return 2 * U - 1;
         2: return 2 * U;
         3: return int'($urandom_range(2, 2 * U));
         4: return int'($urandom_range(2 * U, 4 * U));
         default: return int'($urandom_range(7 * U, 8 * U));
      endcase
   endfunction

   function automatic int rnd_intra();
      case ($urandom_range(0, 4))
         0: return 1;
         1: return 2 * U - 1;
         2: return 2 * U;
         3: return int'($urandom_range(2, 2 * U - 2));
         default: return U;
      endcase
   endfunction

   function automatic int rnd_gap();
      case ($urandom_range(0, 7))
         0: return 2 * U;
         1: return 2 * U + 1;
         2: return 3 * U;
         3: return 5 * U - 1;
         4: return 5 * U;
         5: return 5 * U + 1;
         6: return 7 * U;
         default: return int'($urandom_range(2 * U, 6 * U));
      endcase
   endfunction

   initial begin
      int b, bw, bl;
      int sos_code[3];
      sos_code = '{0, 7, 0};
      model_reset();
      RESETN = 1'b0;
      drive(1'b0, 4);
      check("reset_outputs", int'({SYM_VALID, SYM_CODE, SYM_LEN, SYM_ERR, WORD_END, LED}), 0);
      RESETN = 1'b1;
      drive(1'b0, 4);

      // SOS
      b = sv_len.size(); bw = we_cyc.size();
      send("...", 3); send("---", 3); send("...", 7);
      check("sos_count", sv_len.size() - b, 3);
      for (int i = 0; i < 3; i++) begin
         check("sos_len", q_at(sv_len, b + i), 3);
         check("sos_code", q_at(sv_code, b + i), sos_code[i]);
      end
      check("sos_word_end", we_cyc.size() - bw, 1);
      check("sos_word_after_last", int'(q_at(we_cyc, bw) > q_at(sv_cyc, b + 2)), 1);

      // one-cycle glitch while idle
      b = sv_len.size(); bw = we_cyc.size(); bl = led_hi;
      drive(1'b1, 1); drive(1'b0, 3 * U);
      check("glitch_led", led_hi - bl, 0);
      check("glitch_sym", sv_len.size() - b, 0);
      check("glitch_word", we_cyc.size() - bw, 0);

      // dot/dash boundary
      b = sv_len.size();
      drive(1'b1, 2 * U - 1); drive(1'b0, 7 * U);
      drive(1'b1, 2 * U);     drive(1'b0, 7 * U);
      check("boundary_count", sv_len.size() - b, 2);
      check("mark31_code", q_at(sv_code, b), 0);
      check("mark31_len", q_at(sv_len, b), 1);
      check("mark32_code", q_at(sv_code, b + 1), 1);
      check("mark32_len", q_at(sv_len, b + 1), 1);

      // overflow: seven dots
      b = sv_len.size();
      send(".......", 7);
      check("ovf_count", sv_len.size() - b, 1);
      check("ovf_len", q_at(sv_len, b), 6);
      check("ovf_code", q_at(sv_code, b), 0);
      check("ovf_err", q_at(sv_err, b), 1);

      // reset mid-letter
      send("..", 1);
      RESETN = 1'b0;
      drive(1'b0, 3);
      check("midreset_outputs", int'({SYM_VALID, SYM_CODE, SYM_LEN, SYM_ERR, WORD_END, LED}), 0);
      RESETN = 1'b1;
      b = sv_len.size(); bw = we_cyc.size();
      send(".", 7);
      check("postreset_len", q_at(sv_len, b), 1);
      check("postreset_code", q_at(sv_code, b), 0);
      check("postreset_err", q_at(sv_err, b), 0);
      check("postreset_word", we_cyc.size() - bw, 1);

      // two letters, one word end
      b = sv_len.size(); bw = we_cyc.size();
      send(".", 3); send(".", 7);
      check("two_count", sv_len.size() - b, 2);
      check("two_len0", q_at(sv_len, b), 1);
      check("two_len1", q_at(sv_len, b + 1), 1);
      check("two_word", we_cyc.size() - bw, 1);
      check("two_word_after", int'(q_at(we_cyc, bw) > q_at(sv_cyc, b + 1)), 1);

      // random keying
      for (int l = 0; l < 25; l++) begin
         int n;
         n = int'($urandom_range(1, 8));
         for (int e = 0; e < n; e++) begin
            drive(1'b1, rnd_mark());
            drive(1'b0, (e == n - 1) ? rnd_gap() : rnd_intra());
         end
      end
      drive(1'b0, 8 * U);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
